// File: rtl/thread_scheduler_pkg.sv
// Shared types for the fetch thread scheduler.
//   NUM_THREADS    : default hardware thread count (must be 2**$bits(threadid_t))
//   threadid_t     : hardware thread identifier
//   thread_state_t : per-thread run state
package thread_scheduler_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;

  typedef logic [TID_W-1:0] threadid_t;

  typedef enum logic {
    TS_READY   = 1'b0,
    TS_BLOCKED = 1'b1
  } thread_state_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Round-robin picker: returns the first set bit of req, scanning from
// last_grant+1 upward and wrapping. N must be a power of two so the index
// wraps by plain truncation.
//   req        in  N   request mask
//   last_grant in  IW  most recently granted index
//   gnt_valid  out 1   some request was set
//   gnt_idx    out IW  selected index (0 when gnt_valid is low)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  // NOTE: every output of a combinational block is given a default first so
  // no path through the loop leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    // Offset N wraps back to last_grant itself, so it is checked last.
    for (int i = 1; i <= N; i++) begin
      idx = last_grant + IW'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained round-robin fetch scheduler. Each cycle offers one eligible
// thread to fetch; a thread whose previous-cycle grant took an iTLB/iCache
// miss is parked until its fill returns, and its history is squashed toward
// the hazard unit in the same cycle the miss is reported.
//   clk, rst          : clock, synchronous active-high reset
//   thread_enable     : per-thread software run enable
//   fetch_ready       : fetch stage accepts the offered grant
//   itlb_miss,
//   icache_miss       : miss for the thread granted in the previous cycle
//   fill_valid,
//   fill_thread       : fill completed for fill_thread
//   fetch_valid,
//   fetch_thread      : combinational grant offer
//   invalidate_en,
//   invalidate_thread : combinational history squash for a missing thread
//   thread_blocked    : per-thread BLOCKED flags
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int N_THREADS = NUM_THREADS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_THREADS-1:0] thread_enable,
  input  logic                 fetch_ready,
  input  logic                 itlb_miss,
  input  logic                 icache_miss,
  input  logic                 fill_valid,
  input  threadid_t            fill_thread,
  output logic                 fetch_valid,
  output threadid_t            fetch_thread,
  output logic                 invalidate_en,
  output threadid_t            invalidate_thread,
  output logic [N_THREADS-1:0] thread_blocked
);

  thread_state_t        state_q [N_THREADS];
  logic                 issued_q;
  threadid_t            issued_thread_q;
  threadid_t            last_grant_q;

  logic [N_THREADS-1:0] blocked;
  logic [N_THREADS-1:0] miss_mask;
  logic [N_THREADS-1:0] eligible;
  logic                 miss_now;
  logic                 gnt_valid;
  threadid_t            gnt_idx;
  logic                 grant;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      blocked[i] = (state_q[i] == TS_BLOCKED);
    end
  end

  // A miss only means something when the previous cycle actually granted.
  assign miss_now  = issued_q && (itlb_miss || icache_miss);
  assign miss_mask = miss_now ? (N_THREADS'(1) << issued_thread_q) : '0;

  // The missing thread is already excluded in the cycle the miss arrives;
  // a fill only takes effect through the registered state (no bypass).
  assign eligible = thread_enable & ~blocked & ~miss_mask;

  rr_arbiter #(
    .N  (N_THREADS),
    .IW ($bits(threadid_t))
  ) u_arb (
    .req        (eligible),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign fetch_valid       = gnt_valid && !rst;
  assign fetch_thread      = gnt_idx;
  assign invalidate_en     = miss_now && !rst;
  assign invalidate_thread = issued_thread_q;
  assign thread_blocked    = blocked;
  assign grant             = fetch_valid && fetch_ready;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q        <= 1'b0;
      issued_thread_q <= '0;
      last_grant_q    <= threadid_t'(N_THREADS - 1);
      for (int i = 0; i < N_THREADS; i++) begin
        state_q[i] <= TS_READY;
      end
    end else begin
      issued_q <= grant;
      if (grant) begin
        issued_thread_q <= fetch_thread;
        last_grant_q    <= fetch_thread;
      end
      // Miss has priority; a fill aimed at a READY thread is a no-op.
      for (int i = 0; i < N_THREADS; i++) begin
        if (miss_mask[i]) begin
          state_q[i] <= TS_BLOCKED;
        end else if (fill_valid && fill_thread == threadid_t'(i)
                     && state_q[i] == TS_BLOCKED) begin
          state_q[i] <= TS_READY;
        end
      end
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: a table of per-cycle stimulus
// records with hand-derived expected outputs, pushed into a scoreboard when
// driven and popped/compared mid-cycle, followed by a directed reset sequence.
module tb_thread_scheduler;
  import thread_scheduler_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       rdy;
    logic       im;
    logic       cm;
    logic       fv;
    logic [1:0] ft;
    logic       ev;    // expected fetch_valid
    logic [1:0] et;    // expected fetch_thread (checked when ev)
    logic       ei;    // expected invalidate_en
    logic [1:0] eit;   // expected invalidate_thread (checked when ei)
    logic [3:0] eb;    // expected thread_blocked
    logic       cb;    // compare thread_blocked this cycle
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] thread_enable = 4'hF;
  logic       fetch_ready = 1'b0;
  logic       itlb_miss = 1'b0;
  logic       icache_miss = 1'b0;
  logic       fill_valid = 1'b0;
  threadid_t  fill_thread = '0;
  logic       fetch_valid;
  threadid_t  fetch_thread;
  logic       invalidate_en;
  threadid_t  invalidate_thread;
  logic [3:0] thread_blocked;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  thread_scheduler #(.N_THREADS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .thread_enable     (thread_enable),
    .fetch_ready       (fetch_ready),
    .itlb_miss         (itlb_miss),
    .icache_miss       (icache_miss),
    .fill_valid        (fill_valid),
    .fill_thread       (fill_thread),
    .fetch_valid       (fetch_valid),
    .fetch_thread      (fetch_thread),
    .invalidate_en     (invalidate_en),
    .invalidate_thread (invalidate_thread),
    .thread_blocked    (thread_blocked)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] en, input logic rdy,
                     input logic im, input logic cm, input logic fv, input logic [1:0] ft,
                     input logic ev, input logic [1:0] et, input logic ei, input logic [1:0] eit,
                     input logic [3:0] eb, input logic cb);
    vec_t v;
    v = '{rst: r, en: en, rdy: rdy, im: im, cm: cm, fv: fv, ft: ft,
          ev: ev, et: et, ei: ei, eit: eit, eb: eb, cb: cb};
    vecs.push_back(v);
  endtask

  // Plain grant cycle: all enabled, ready, no miss/fill.
  task automatic g(input logic [1:0] t, input logic [3:0] eb);
    add(0, 4'hF, 1, 0, 0, 0, 0, 1, t, 0, 0, eb, 1);
  endtask

  // Drive one cycle just after the edge, then pop and compare mid-cycle.
  task automatic run_vec(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; thread_enable = v.en; fetch_ready = v.rdy;
    itlb_miss = v.im; icache_miss = v.cm; fill_valid = v.fv; fill_thread = v.ft;
    exp_q.push_back(v);
    #3;
    e = exp_q.pop_front();
    check($sformatf("v%0d fetch_valid", vec_no), 32'(fetch_valid), 32'(e.ev));
    if (e.ev) check($sformatf("v%0d fetch_thread", vec_no), 32'(fetch_thread), 32'(e.et));
    check($sformatf("v%0d invalidate_en", vec_no), 32'(invalidate_en), 32'(e.ei));
    if (e.ei) check($sformatf("v%0d invalidate_thread", vec_no), 32'(invalidate_thread), 32'(e.eit));
    if (e.cb) check($sformatf("v%0d thread_blocked", vec_no), 32'(thread_blocked), 32'(e.eb));
    vec_no++;
  endtask

  initial begin
    // Reset: outputs quiet during rst, state clear after one edge.
    add(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
    // Plain rotation starting at thread 0.
    g(0, 4'h0); g(1, 4'h0); g(2, 4'h0); g(3, 4'h0); g(0, 4'h0); g(1, 4'h0);
    // icache miss for T1: squashed, skipped until its fill, then returns.
    add(0, 4'hF, 1, 0, 1, 0, 0, 1, 2, 1, 1, 4'h0, 1);
    g(3, 4'h2); g(0, 4'h2); g(2, 4'h2); g(3, 4'h2);
    add(0, 4'hF, 1, 0, 0, 1, 1, 1, 0, 0, 0, 4'h2, 1);   // fill T1, no bypass
    g(1, 4'h0);
    // Block T1 again, then miss T2 together with fill T1.
    add(0, 4'hF, 1, 0, 1, 0, 0, 1, 2, 1, 1, 4'h0, 1);
    g(3, 4'h2); g(0, 4'h2); g(2, 4'h2);
    add(0, 4'hF, 1, 1, 0, 1, 1, 1, 3, 1, 2, 4'h2, 1);
    g(0, 4'h4);
    // Miss every remaining thread until nothing is eligible.
    add(0, 4'hF, 1, 0, 1, 0, 0, 1, 1, 1, 0, 4'h4, 1);
    add(0, 4'hF, 1, 0, 1, 0, 0, 1, 3, 1, 1, 4'h5, 1);
    add(0, 4'hF, 1, 0, 1, 0, 0, 0, 0, 1, 3, 4'h7, 1);
    // All blocked, no issue last cycle: miss ignored; fill T3.
    add(0, 4'hF, 1, 0, 1, 1, 3, 0, 0, 0, 0, 4'hF, 1);
    g(3, 4'h7);
    add(0, 4'hF, 1, 0, 0, 1, 0, 1, 3, 0, 0, 4'h7, 1);
    add(0, 4'hF, 1, 0, 0, 1, 1, 1, 0, 0, 0, 4'h6, 1);
    add(0, 4'hF, 1, 0, 0, 1, 2, 1, 1, 0, 0, 4'h4, 1);
    // fetch_ready low for three cycles while T2 offered; READY fill ignored.
    add(0, 4'hF, 0, 0, 0, 1, 0, 1, 2, 0, 0, 4'h0, 1);
    add(0, 4'hF, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4'h0, 1);
    add(0, 4'hF, 0, 0, 1, 0, 0, 1, 2, 0, 0, 4'h0, 1);
    g(2, 4'h0); g(3, 4'h0);
    // Software-disabled T2 is skipped.
    add(0, 4'hB, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1);
    add(0, 4'hB, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 1);
    add(0, 4'hB, 1, 0, 0, 0, 0, 1, 3, 0, 0, 4'h0, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Directed: T1 BLOCKED, rst mid-operation, late fill for T1 ignored.
    vecs.delete();
    g(0, 4'h0); g(1, 4'h0);
    add(0, 4'hF, 1, 0, 1, 0, 0, 1, 2, 1, 1, 4'h0, 1);
    g(3, 4'h2);
    add(1, 4'hF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'h2, 1);   // rst masks the miss
    add(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 1, 0, 0, 1, 1, 1, 0, 0, 0, 4'h0, 1);
    g(1, 4'h0);
    foreach (vecs[i]) run_vec(vecs[i]);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
